tb_reorder_lifo: RTL and testbench
==================================

# tb_reorder_lifo

Output reordering stage placed directly downstream of the traceback unit. Traceback emits the decoded bits of each traceback block newest-first. This block buffers one block at a time and replays it oldest-first, so the decoder output is in transmission order. Two ping-pong banks let the next block be written while the previous one drains, with a valid/ready handshake on the output side.

## Interface
- DEPTH, default 64: maximum bits per traceback block, which is the traceback depth.
- WD_ADDR, default 6: bank address width; must equal ceil(log2(DEPTH)).
- Clock  in  1  sole clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high; sampled on posedge Clock.
- InValid  in  1  InBit is valid this cycle.
- InBit  in  1  decoded bit from traceback, newest-first within a block.
- InLast  in  1  with InValid: this is the final bit of the current block.
- InReady  out  1  a write bank is available; the bit is accepted when InValid && InReady.
- OutBit  out  1  reordered decoded bit.
- OutValid  out  1  OutBit/OutLast are valid.
- OutLast  out  1  oldest bit of the block, i.e. its last output beat.
- OutReady  in  1  the consumer accepts a beat when OutValid && OutReady.

## Operation
- Two banks, 0 and 1. Each bank holds DEPTH bits, a length register (1..DEPTH) and a state: EMPTY, FILLING, FULL or DRAINING.
- Write side:
  - The write bank pointer starts at 0.
  - An accepted bit is stored at index wcnt, then wcnt increments.
  - The bank closes on an accepted bit that has InLast=1, or when wcnt reaches DEPTH (auto-close).
  - On close: length = wcnt+1 and state = FULL. The write pointer toggles, and wcnt = 0.
- InReady = 1 when the current write bank is EMPTY or FILLING. It is 0 when that bank is FULL or DRAINING.
- Read FSM has two states, IDLE and DRAIN:
  - IDLE → DRAIN when the bank at the read pointer is FULL. Set rptr = length−1 and mark the bank DRAINING.
  - In DRAIN, OutBit = bank[rptr]. rptr decrements on each accepted beat.
  - OutLast = 1 when rptr == 0.
  - An accepted beat with OutLast: bank goes EMPTY and the read pointer toggles.
  - If the other bank is already FULL on that cycle, stay in DRAIN and load it, with no bubble. Otherwise go to IDLE.
- Holding rules:
  - While OutValid && !OutReady, OutBit and OutLast are held stable.
  - InValid with InReady=0: the bit is dropped and no state changes.
  - InLast on a bit that lands exactly at index DEPTH−1 gives one close, not two.
- Blocks longer than DEPTH are split into DEPTH-bit segments. Each segment ends with its own OutLast.
- Simultaneous write-close and read-finish on opposite banks are both honoured in the same cycle.
- Writing a bank that is draining is impossible, because InReady gates it.

## Timing
- Reset values:
  - OutValid=0, OutBit=0, OutLast=0, InReady=1.
  - Both banks EMPTY, both pointers 0, wcnt 0, read FSM IDLE.
- Reset asserted mid-operation discards all buffered bits on that edge. It has priority over every other event.
- Latency: the first OutValid is asserted in the cycle after the closing write edge. Outputs are registered.
- Throughput: 1 bit per cycle sustained on both sides while OutReady=1.
- Output order for a block written b0..bN−1 is bN−1 first, down to b0, with OutLast on b0.

## Configuration
- TBLIFO_DROPCNT_EN defined:
  - Adds output DropCount [7:0].
  - It counts cycles with InValid && !InReady, saturates at 255, and clears on Reset.
- TBLIFO_DROPCNT_EN undefined:
  - The port and counter are absent.
  - Dropped bits are silent, and all other behaviour is identical.

## Structure
- Constants go in the shared params.v: `WD_TB_DEPTH (64) and `WD_TB_ADDR (6). Module parameters default to these.
- The bank state encoding (EMPTY, FILLING, FULL, DRAINING as 2-bit values) is also defined in params.v.
- One sub-module: tblifo_bank. It contains the storage array, the length register, the state register, a write port and a registered read port. It is instantiated twice.
- Top level: write-pointer logic, read FSM, and the optional drop counter.

## Test plan
- Reset, then write 5 bits 1,0,1,1,0 with InLast on the 5th, OutReady=1 → output 0,1,1,0,1. OutLast is on the 5th beat and OutValid rises 1 cycle after the close.
- Write 64 bits, alternating, with no InLast → auto-close. Output is 64 beats reversed. InReady stays 1, and a second block is written during the drain.
- Write two 3-bit blocks back-to-back while OutReady=0 → InReady=0 after the second close, and a third-block bit is dropped (DropCount=1 when enabled). Then OutReady=1 → 6 beats with no bubble between blocks.
- Toggle OutReady 1,0,0,1 during a drain → OutBit and OutLast hold while stalled, and no beat is lost or duplicated.
- Assert Reset mid-drain → next cycle OutValid=0 and InReady=1. A new 2-bit block then drains correctly.
- 1-bit block (InLast on the first bit) → one beat with OutLast=1.

Source files
------------

// File: rtl/tb_reorder_lifo_pkg.sv
// Shared constants and types for the traceback output reordering LIFO.
package tb_reorder_lifo_pkg;

  // Traceback depth in bits and the matching bank address width.
  localparam int WD_TB_DEPTH = 64;
  localparam int WD_TB_ADDR  = 6;

  // Per-bank occupancy state.
  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // Read-side sequencer state.
  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;

  // A bank can take write data only while it is not holding a closed block.
  function automatic logic is_writable(input bank_state_e s);
    return (s == BANK_EMPTY) || (s == BANK_FILLING);
  endfunction

endpackage

// File: rtl/tblifo_bank.sv
// One ping-pong bank: bit storage, block length (kept as length-1),
// occupancy state, a write port and a registered read port.
module tblifo_bank
  import tb_reorder_lifo_pkg::*;
#(
  parameter int DEPTH   = WD_TB_DEPTH,
  parameter int WD_ADDR = WD_TB_ADDR
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               wr_en,
  input  logic               wr_close,
  input  logic [WD_ADDR-1:0] wr_addr,
  input  logic               wr_bit,
  input  logic               start_drain,
  input  logic               drain_done,
  input  logic               rd_en,
  input  logic [WD_ADDR-1:0] rd_addr,
  output logic               rd_bit,
  output bank_state_e        state,
  output logic [WD_ADDR-1:0] last_idx
);

  logic [DEPTH-1:0]   mem_q, mem_d;
  bank_state_e        state_q, state_d;
  logic [WD_ADDR-1:0] len_m1_q, len_m1_d;   // block length minus one
  logic               rd_bit_q, rd_bit_d;

  // Next-state for storage, read data, length and occupancy.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    mem_d    = mem_q;
    rd_bit_d = rd_bit_q;
    state_d  = state_q;
    len_m1_d = len_m1_q;
    if (wr_en) mem_d[wr_addr] = wr_bit;
    if (rd_en) rd_bit_d = mem_q[rd_addr];
    case (state_q)
      BANK_EMPTY, BANK_FILLING: begin
        if (wr_en) begin
          if (wr_close) begin
            state_d  = BANK_FULL;
            len_m1_d = wr_addr;
          end else begin
            state_d  = BANK_FILLING;
          end
        end
      end
      BANK_FULL:     if (start_drain) state_d = BANK_DRAINING;
      BANK_DRAINING: if (drain_done)  state_d = BANK_EMPTY;
      default:       state_d = BANK_EMPTY;
    endcase
  end

  // Storage array register.
  always_ff @(posedge Clock) begin
    // NOTE: the bit array is deliberately not reset; bank state gates every read of it.
    mem_q <= mem_d;
  end

  // Control registers with synchronous reset.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (Reset) begin
      state_q  <= BANK_EMPTY;
      len_m1_q <= '0;
      rd_bit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_m1_q <= len_m1_d;
      rd_bit_q <= rd_bit_d;
    end
  end

  assign rd_bit   = rd_bit_q;
  assign state    = state_q;
  assign last_idx = len_m1_q;

endmodule

// File: rtl/tb_reorder_lifo.sv
// Traceback output reordering stage: writes each block newest-first into one
// of two banks and replays it oldest-first over a valid/ready output.
// Optional feature: define TBLIFO_DROPCNT_EN to add the DropCount output.
module tb_reorder_lifo
  import tb_reorder_lifo_pkg::*;
#(
  parameter int DEPTH   = WD_TB_DEPTH,
  parameter int WD_ADDR = WD_TB_ADDR
) (
  input  logic Clock,
  input  logic Reset,
  input  logic InValid,
  input  logic InBit,
  input  logic InLast,
  output logic InReady,
  output logic OutBit,
  output logic OutValid,
  output logic OutLast,
  input  logic OutReady
`ifdef TBLIFO_DROPCNT_EN
  ,
  output logic [7:0] DropCount
`endif
);

  localparam logic [WD_ADDR-1:0] ONE_A    = WD_ADDR'(1);
  localparam logic [WD_ADDR-1:0] LAST_IDX = WD_ADDR'(DEPTH - 1);

  bank_state_e        bank_state [2];
  logic [WD_ADDR-1:0] bank_last  [2];
  logic [1:0]         bank_rd_bit;
  logic [1:0]         wr_en, wr_close, start_drain, drain_done, rd_en;
  logic [WD_ADDR-1:0] rd_addr;

  logic               wsel_q, wsel_d;
  logic [WD_ADDR-1:0] wcnt_q, wcnt_d;
  rd_state_e          rd_state_q, rd_state_d;
  logic               rsel_q, rsel_d;
  logic [WD_ADDR-1:0] rptr_q, rptr_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;

  logic in_ready, accept, close, beat, other;

  for (genvar i = 0; i < 2; i++) begin : g_bank
    tblifo_bank #(.DEPTH(DEPTH), .WD_ADDR(WD_ADDR)) u_bank (
      .Clock       (Clock),
      .Reset       (Reset),
      .wr_en       (wr_en[i]),
      .wr_close    (wr_close[i]),
      .wr_addr     (wcnt_q),
      .wr_bit      (InBit),
      .start_drain (start_drain[i]),
      .drain_done  (drain_done[i]),
      .rd_en       (rd_en[i]),
      .rd_addr     (rd_addr),
      .rd_bit      (bank_rd_bit[i]),
      .state       (bank_state[i]),
      .last_idx    (bank_last[i])
    );
  end

  assign in_ready = is_writable(bank_state[wsel_q]);
  assign accept   = InValid && in_ready;
  // InLast on index DEPTH-1 and auto-close coincide into a single close.
  assign close    = accept && (InLast || (wcnt_q == LAST_IDX));
  assign beat     = out_valid_q && OutReady;
  assign other    = ~rsel_q;

  // Write side: store at wcnt, close the bank and swap on last bit or full.
  always_comb begin
    wsel_d   = wsel_q;
    wcnt_d   = wcnt_q;
    wr_en    = '0;
    wr_close = '0;
    if (accept) begin
      wr_en[wsel_q] = 1'b1;
      if (close) begin
        wr_close[wsel_q] = 1'b1;
        wsel_d           = ~wsel_q;
        wcnt_d           = '0;
      end else begin
        wcnt_d = wcnt_q + ONE_A;
      end
    end
  end

  // Read sequencer: load the newest bit of a full bank, walk down to index 0,
  // then chain straight into the other bank if it is already full.
  always_comb begin
    rd_state_d  = rd_state_q;
    rsel_d      = rsel_q;
    rptr_d      = rptr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    start_drain = '0;
    drain_done  = '0;
    rd_en       = '0;
    rd_addr     = rptr_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (bank_state[rsel_q] == BANK_FULL) begin
          start_drain[rsel_q] = 1'b1;
          rd_en[rsel_q]       = 1'b1;
          rd_addr             = bank_last[rsel_q];
          rptr_d              = rd_addr;
          out_valid_d         = 1'b1;
          out_last_d          = (rd_addr == '0);
          rd_state_d          = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (beat) begin
          if (out_last_q) begin
            drain_done[rsel_q] = 1'b1;
            rsel_d             = other;
            if (bank_state[other] == BANK_FULL) begin
              start_drain[other] = 1'b1;
              rd_en[other]       = 1'b1;
              rd_addr            = bank_last[other];
              rptr_d             = rd_addr;
              out_last_d         = (rd_addr == '0);
            end else begin
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              rd_state_d  = RD_IDLE;
            end
          end else begin
            rd_en[rsel_q] = 1'b1;
            rd_addr       = rptr_q - ONE_A;
            rptr_d        = rd_addr;
            out_last_d    = (rd_addr == '0);
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Pointer, counter and output-flag registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wsel_q      <= 1'b0;
      wcnt_q      <= '0;
      rd_state_q  <= RD_IDLE;
      rsel_q      <= 1'b0;
      rptr_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      wsel_q      <= wsel_d;
      wcnt_q      <= wcnt_d;
      rd_state_q  <= rd_state_d;
      rsel_q      <= rsel_d;
      rptr_q      <= rptr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign InReady  = in_ready;
  assign OutValid = out_valid_q;
  assign OutLast  = out_last_q;
  assign OutBit   = bank_rd_bit[rsel_q];

`ifdef TBLIFO_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of cycles that offered a bit while no bank was free.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (InValid && !in_ready && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Drop counter register.
  always_ff @(posedge Clock) begin
    if (Reset) drop_cnt_q <= 8'd0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign DropCount = drop_cnt_q;
`endif

endmodule

// File: tb/tb_tb_reorder_lifo.sv
// Self-checking bench for tb_reorder_lifo: a cycle table for the first block,
// then scoreboard-checked sequences for the multi-cycle corner cases.
module tb_tb_reorder_lifo;

  localparam int DEPTH = 64;

  logic Clock = 1'b0;
  logic Reset, InValid, InBit, InLast, OutReady;
  logic InReady, OutBit, OutValid, OutLast;
`ifdef TBLIFO_DROPCNT_EN
  logic [7:0] DropCount;
`endif

  tb_reorder_lifo #(.DEPTH(DEPTH), .WD_ADDR(6)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .InValid  (InValid),
    .InBit    (InBit),
    .InLast   (InLast),
    .InReady  (InReady),
    .OutBit   (OutBit),
    .OutValid (OutValid),
    .OutLast  (OutLast),
    .OutReady (OutReady)
`ifdef TBLIFO_DROPCNT_EN
    ,
    .DropCount(DropCount)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic in_valid, in_bit, in_last, out_ready;
    logic exp_ready, exp_valid, exp_bit, exp_last;
  } vec_t;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;
  exp_t exp_q[$];
  logic model_blk[$];
  vec_t tbl[11];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a closed block replays newest bit first, OutLast on the oldest.
  task automatic close_block();
    for (int i = model_blk.size() - 1; i >= 0; i--) exp_q.push_back('{b: model_blk[i], last: (i == 0)});
    model_blk.delete();
  endtask

  task automatic drive_bit(input logic b, input logic last, input logic exp_acc);
    InValid = 1'b1;
    InBit   = b;
    InLast  = last;
    check("in_ready", int'(InReady), int'(exp_acc));
    @(posedge Clock); #1;
    InValid = 1'b0;
    InLast  = 1'b0;
    if (exp_acc) begin
      model_blk.push_back(b);
      if (last || model_blk.size() == DEPTH) close_block();
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge Clock); #1;
      n++;
    end
    check("drain_timeout_left", exp_q.size(), 0);
    repeat (2) @(posedge Clock);
    #1;
  endtask

  task automatic wait_valid(input int max_cyc);
    int n = 0;
    while (!OutValid && n < max_cyc) begin
      @(posedge Clock); #1;
      n++;
    end
    check("valid_timeout", int'(OutValid), 1);
  endtask

  // Scoreboard monitor: every valid beat must match the queue head; pop on acceptance.
  initial begin
    forever begin
      @(negedge Clock);
      if (mon_en && !Reset && OutValid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", int'(OutValid), 0);
        end else begin
          check("out_bit", int'(OutBit), int'(exp_q[0].b));
          check("out_last", int'(OutLast), int'(exp_q[0].last));
          if (OutReady) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int ready_pat[11];
    Reset = 1'b1; InValid = 1'b0; InBit = 1'b0; InLast = 1'b0; OutReady = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_out_valid", int'(OutValid), 0);
    check("rst_out_bit", int'(OutBit), 0);
    check("rst_out_last", int'(OutLast), 0);
    check("rst_in_ready", int'(InReady), 1);
`ifdef TBLIFO_DROPCNT_EN
    check("rst_drop_count", int'(DropCount), 0);
`endif
    Reset = 1'b0;

    // Block 1,0,1,1,0 (InLast on the fifth) replays as 0,1,1,0,1; outputs checked after each edge.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 11; k++) begin
      InValid = tbl[k].in_valid; InBit = tbl[k].in_bit; InLast = tbl[k].in_last; OutReady = tbl[k].out_ready;
      @(posedge Clock); #1;
      check($sformatf("tbl%0d_in_ready", k), int'(InReady), int'(tbl[k].exp_ready));
      check($sformatf("tbl%0d_out_valid", k), int'(OutValid), int'(tbl[k].exp_valid));
      check($sformatf("tbl%0d_out_last", k), int'(OutLast), int'(tbl[k].exp_last));
      if (tbl[k].exp_valid) check($sformatf("tbl%0d_out_bit", k), int'(OutBit), int'(tbl[k].exp_bit));
    end
    InValid = 1'b0; InLast = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    mon_en = 1'b1;

    // 64 alternating bits auto-close; a second block is written during the drain.
    for (int i = 0; i < DEPTH; i++) drive_bit((i % 2) == 1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive_bit(1'($urandom_range(0, 1)), i == 9, 1'b1);
    wait_drain(300);

    // InLast on index DEPTH-1 closes once; the following short block stays separate.
    for (int i = 0; i < DEPTH; i++) drive_bit(1'($urandom_range(0, 1)), i == DEPTH - 1, 1'b1);
    drive_bit(1'b1, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1, 1'b1);
    wait_drain(300);

    // Two 3-bit blocks while stalled fill both banks; a third-block bit is dropped.
    OutReady = 1'b0;
    drive_bit(1'b1, 1'b0, 1'b1); drive_bit(1'b1, 1'b0, 1'b1); drive_bit(1'b0, 1'b1, 1'b1);
    drive_bit(1'b0, 1'b0, 1'b1); drive_bit(1'b1, 1'b0, 1'b1); drive_bit(1'b1, 1'b1, 1'b1);
    check("in_ready_both_full", int'(InReady), 0);
    drive_bit(1'b1, 1'b0, 1'b0);
`ifdef TBLIFO_DROPCNT_EN
    check("drop_count_one", int'(DropCount), 1);
`endif
    OutReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      check($sformatf("no_bubble_%0d", i), int'(OutValid), 1);
    end
    @(negedge Clock);
    check("valid_after_six", int'(OutValid), 0);
    wait_drain(50);

    // OutReady toggled 1,0,0,1 mid-drain: held beats are rechecked against the queue head.
    OutReady = 1'b0;
    for (int i = 0; i < 8; i++) drive_bit(1'($urandom_range(0, 1)), i == 7, 1'b1);
    wait_valid(10);
    ready_pat = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
    for (int i = 0; i < 11; i++) begin
      OutReady = (ready_pat[i] != 0);
      @(posedge Clock); #1;
    end
    OutReady = 1'b1;
    wait_drain(50);

    // Reset mid-drain discards everything; a fresh 2-bit block then drains.
    for (int i = 0; i < 10; i++) drive_bit(1'($urandom_range(0, 1)), i == 9, 1'b1);
    repeat (4) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    exp_q.delete();
    model_blk.delete();
    check("midrst_out_valid", int'(OutValid), 0);
    check("midrst_in_ready", int'(InReady), 1);
    check("midrst_out_last", int'(OutLast), 0);
`ifdef TBLIFO_DROPCNT_EN
    check("midrst_drop_count", int'(DropCount), 0);
`endif
    drive_bit(1'b1, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1, 1'b1);
    wait_drain(20);

    // Single-bit block: one beat carrying OutLast.
    drive_bit(1'b1, 1'b1, 1'b1);
    wait_valid(5);
    check("one_bit_last", int'(OutLast), 1);
    wait_drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
